// File: rtl/rx_streamer_block_pkg.sv
// Shared types and helpers for the rx_streamer block reassembly buffer.
// Holds the write-FSM state type and the sizing arithmetic.
package rx_streamer_block_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DROP = 2'd2
  } t_blk_wr_state;

  function automatic int f_log2_ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int c_def_max_words = 16;
  localparam int c_def_num_slots = 4;
  localparam int c_len_width     = f_log2_ceil(c_def_max_words) + 1;
  localparam int c_addr_width    =
    f_log2_ceil(c_def_num_slots * c_def_max_words);

endpackage

// File: rtl/rx_block_buffer_ram.sv
// Simple dual-port block store: one write port, one registered read port.
// The read register holds its value while no read is requested.
module rx_block_buffer_ram
  import rx_streamer_block_pkg::*;
#(
  parameter int g_data_width = 64,
  parameter int g_addr_width = c_addr_width,
  parameter int g_depth      = 1 << g_addr_width
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_we,
  input  logic [g_addr_width-1:0] i_waddr,
  input  logic [g_data_width-1:0] i_wdata,
  input  logic                    i_re,
  input  logic [g_addr_width-1:0] i_raddr,
  output logic [g_data_width-1:0] o_rdata
);

  logic [g_data_width-1:0] r_mem [g_depth];
  logic [g_data_width-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_q <= '0;
    else if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/rx_streamer_block_buffer.sv
// Reassembles rx_streamer words into fixed-size slots and releases
// only complete blocks; malformed blocks are dropped and counted.
module rx_streamer_block_buffer
  import rx_streamer_block_pkg::*;
#(
  parameter int g_data_width = 64,
  parameter int g_max_words  = 16,
  parameter int g_num_slots  = 4,
  parameter int g_cnt_width  = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [g_data_width-1:0]            snk_data_i,
  input  logic                               snk_valid_i,
  input  logic                               snk_first_i,
  input  logic                               snk_last_i,
  input  logic                               snk_lost_i,
  output logic                               snk_dreq_o,
  output logic [g_data_width-1:0]            src_data_o,
  output logic                               src_valid_o,
  output logic                               src_first_o,
  output logic                               src_last_o,
  input  logic                               src_ready_i,
  output logic [f_log2_ceil(g_max_words):0]  src_len_o,
  input  logic                               stat_clr_i,
  output logic [g_cnt_width-1:0]             stat_ok_o,
  output logic [g_cnt_width-1:0]             stat_drop_lost_o,
  output logic [g_cnt_width-1:0]             stat_drop_size_o,
  output logic [g_cnt_width-1:0]             stat_drop_misc_o
);

  localparam int c_idx_w  = f_log2_ceil(g_max_words);
  localparam int c_slot_w = f_log2_ceil(g_num_slots);
  localparam int c_lw     = c_idx_w + 1;
  localparam int c_ow     = c_slot_w + 1;
  localparam int c_aw     = c_slot_w + c_idx_w;

  localparam logic [c_lw-1:0] c_max   = c_lw'(g_max_words);
  localparam logic [c_lw-1:0] c_one   = c_lw'(1);
  localparam logic [c_ow-1:0] c_slots = c_ow'(g_num_slots);
  localparam logic [c_ow-1:0] c_oone  = c_ow'(1);

  // write side
  t_blk_wr_state          r_state;
  t_blk_wr_state          w_nstate;
  logic [c_lw-1:0]        r_wr_cnt;
  logic [c_lw-1:0]        w_ncnt;
  logic [c_lw-1:0]        w_clen;
  logic [c_slot_w-1:0]    r_wr_slot;
  logic [c_idx_w-1:0]     w_widx;
  logic                   w_we;
  logic                   w_commit;
  logic                   w_inc_lost;
  logic                   w_inc_size;
  logic                   w_inc_misc;
  logic                   w_free;
  logic [c_ow-1:0]        r_occ;
  logic [c_ow-1:0]        w_occ_nxt;
  logic [c_lw-1:0]        r_len [g_num_slots];
  logic                   r_dreq;

  // read side
  logic [c_slot_w-1:0]    r_iss_slot;
  logic [c_idx_w-1:0]     r_iss_idx;
  logic [c_ow-1:0]        r_iss_blk;
  logic [c_ow-1:0]        w_iss_blk_nxt;
  logic                   r_vld;
  logic                   r_first;
  logic                   r_last;
  logic [c_lw-1:0]        r_olen;
  logic [c_lw-1:0]        w_ilen;
  logic                   w_ilast;
  logic                   w_iss;
  logic                   w_rel;
  logic [g_data_width-1:0] w_rdata;

  // statistics
  logic [g_cnt_width-1:0] r_stat [4];
  logic [3:0]             w_inc;

  assign w_free = (r_occ < c_slots);

  always_comb begin
    w_nstate   = r_state;
    w_ncnt     = r_wr_cnt;
    w_we       = 1'b0;
    w_widx     = '0;
    w_commit   = 1'b0;
    w_clen     = r_wr_cnt + c_one;
    w_inc_lost = 1'b0;
    w_inc_size = 1'b0;
    w_inc_misc = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (snk_valid_i && snk_first_i) begin
          if (w_free) begin
            w_we   = 1'b1;
            w_ncnt = c_one;
            if (snk_last_i) begin
              w_commit = 1'b1;
              w_clen   = c_one;
            end else begin
              w_nstate = FILL;
            end
          end else begin
            w_inc_misc = 1'b1;
            if (!snk_last_i) w_nstate = DROP;
          end
        end else if (snk_valid_i) begin
          w_inc_misc = 1'b1;
        end
      end
      FILL: begin
        // lost wins over a word arriving in the same cycle
        if (snk_lost_i) begin
          w_inc_lost = 1'b1;
          w_nstate   = IDLE;
        end else if (snk_valid_i && snk_first_i) begin
          w_inc_lost = 1'b1;
          w_we       = 1'b1;
          w_ncnt     = c_one;
          if (snk_last_i) begin
            w_commit = 1'b1;
            w_clen   = c_one;
            w_nstate = IDLE;
          end
        end else if (snk_valid_i) begin
          if (r_wr_cnt == c_max) begin
            w_inc_size = 1'b1;
            w_nstate   = snk_last_i ? IDLE : DROP;
          end else begin
            w_we   = 1'b1;
            w_widx = r_wr_cnt[c_idx_w-1:0];
            w_ncnt = r_wr_cnt + c_one;
            if (snk_last_i) begin
              w_commit = 1'b1;
              w_nstate = IDLE;
            end
          end
        end
      end
      DROP: begin
        if (snk_lost_i || (snk_valid_i && snk_last_i)) w_nstate = IDLE;
      end
      default: w_nstate = IDLE;
    endcase
  end

  always_comb begin
    w_occ_nxt = r_occ;
    unique case ({w_commit, w_rel})
      2'b10:   w_occ_nxt = r_occ + c_oone;
      2'b01:   w_occ_nxt = r_occ - c_oone;
      default: w_occ_nxt = r_occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_wr_cnt  <= '0;
      r_wr_slot <= '0;
      r_occ     <= '0;
      r_dreq    <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_wr_cnt <= w_ncnt;
      r_occ    <= w_occ_nxt;
      r_dreq   <= (w_occ_nxt < c_slots);
      if (w_commit) r_wr_slot <= r_wr_slot + c_slot_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) r_len[r_wr_slot] <= w_clen;
  end

  // The RAM read register doubles as the output data register.
  assign w_ilen  = r_len[r_iss_slot];
  assign w_ilast = ({1'b0, r_iss_idx} == (w_ilen - c_one));
  assign w_iss   = (r_iss_blk != '0) && (!r_vld || src_ready_i);
  assign w_rel   = r_vld && src_ready_i && r_last;

  always_comb begin
    w_iss_blk_nxt = r_iss_blk;
    unique case ({w_commit, w_iss && w_ilast})
      2'b10:   w_iss_blk_nxt = r_iss_blk + c_oone;
      2'b01:   w_iss_blk_nxt = r_iss_blk - c_oone;
      default: w_iss_blk_nxt = r_iss_blk;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_iss_slot <= '0;
      r_iss_idx  <= '0;
      r_iss_blk  <= '0;
      r_vld      <= 1'b0;
      r_first    <= 1'b0;
      r_last     <= 1'b0;
      r_olen     <= '0;
    end else begin
      r_iss_blk <= w_iss_blk_nxt;
      if (w_iss) begin
        r_vld   <= 1'b1;
        r_first <= (r_iss_idx == '0);
        r_last  <= w_ilast;
        r_olen  <= w_ilen;
        if (w_ilast) begin
          r_iss_slot <= r_iss_slot + c_slot_w'(1);
          r_iss_idx  <= '0;
        end else begin
          r_iss_idx <= r_iss_idx + c_idx_w'(1);
        end
      end else if (src_ready_i) begin
        r_vld   <= 1'b0;
        r_first <= 1'b0;
        r_last  <= 1'b0;
        r_olen  <= '0;
      end
    end
  end

  rx_block_buffer_ram #(
    .g_data_width (g_data_width),
    .g_addr_width (c_aw),
    .g_depth      (g_num_slots * g_max_words)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr ({r_wr_slot, w_widx}),
    .i_wdata (snk_data_i),
    .i_re    (w_iss),
    .i_raddr ({r_iss_slot, r_iss_idx}),
    .o_rdata (w_rdata)
  );

  assign w_inc = {w_inc_misc, w_inc_size, w_inc_lost, w_commit};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n || stat_clr_i) r_stat[i] <= '0;
      else if (w_inc[i] && !(&r_stat[i]))
        r_stat[i] <= r_stat[i] + g_cnt_width'(1);
    end
  end

  assign snk_dreq_o       = r_dreq;
  assign src_data_o       = w_rdata;
  assign src_valid_o      = r_vld;
  assign src_first_o      = r_first;
  assign src_last_o       = r_last;
  assign src_len_o        = r_olen;
  assign stat_ok_o        = r_stat[0];
  assign stat_drop_lost_o = r_stat[1];
  assign stat_drop_size_o = r_stat[2];
  assign stat_drop_misc_o = r_stat[3];

endmodule
